// File: rtl/gpu_interp_pkg.sv
// rtl/gpu_interp_pkg.sv - shared widths, state enum and helpers for the span attribute evaluator
//
// Contents:
//   COORD_W, ATTR_W, COEF_W, FRAC_BITS, ACC_W  datapath widths
//   state_e                                    span FSM states (IDLE, SETUP, RUN)
//   sext_coef()                                sign-extend a plane coefficient to accumulator width
//   zext_coord()                               zero-extend a pixel coordinate to accumulator width
package gpu_interp_pkg;

    localparam int COORD_W   = 12;
    localparam int ATTR_W    = 12;
    localparam int COEF_W    = 32;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    function automatic logic signed [ACC_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
        return $signed({{(ACC_W-COEF_W){c[COEF_W-1]}}, c});
    endfunction

    function automatic logic signed [ACC_W-1:0] zext_coord(input logic [COORD_W-1:0] v);
        return $signed({{(ACC_W-COORD_W){1'b0}}, v});
    endfunction

endpackage

// File: rtl/attr_fmt.sv
// rtl/attr_fmt.sv - combinational accumulator-to-attribute formatter (shift, then clamp or wrap)
//
// Ports:
//   acc_i   in  ACC_W   signed fixed-point accumulator, FRAC_BITS fractional bits
//   attr_o  out ATTR_W  integer attribute
//
// Build option: ATTR_CLAMP_EN defined -> saturate to [0, 2^ATTR_W-1];
//               undefined           -> keep the low ATTR_W bits (wrap).
module attr_fmt
    import gpu_interp_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    output logic [ATTR_W-1:0] attr_o
);

    localparam int SH_W = ACC_W - FRAC_BITS;

    // Dropping the fractional bits of a two's complement value is an
    // arithmetic shift that truncates toward -inf.
    logic [SH_W-1:0] shifted;
    assign shifted = acc_i[ACC_W-1:FRAC_BITS];

    logic unused_frac;
    assign unused_frac = ^acc_i[FRAC_BITS-1:0];

`ifdef ATTR_CLAMP_EN
    always_comb begin
        attr_o = shifted[ATTR_W-1:0];
        if (shifted[SH_W-1]) begin
            attr_o = '0;
        end else if (|shifted[SH_W-2:ATTR_W]) begin
            attr_o = '1;
        end
    end
`else
    assign attr_o = shifted[ATTR_W-1:0];

    logic unused_high;
    assign unused_high = ^shifted[SH_W-1:ATTR_W];
`endif

endmodule

// File: rtl/attr_span_eval.sv
// rtl/attr_span_eval.sv - walks a horizontal pixel span and emits a plane-equation attribute per pixel
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   coef_load, cx, cy, cs            plane coefficient load (signed, 8 fractional bits), honoured in IDLE only
//   span_valid/span_ready            span request handshake
//   span_x, span_y, span_len         start pixel and pixel count
//   pix_valid/pix_ready              pixel output handshake
//   pix_x, pix_y, pix_s, pix_last    pixel coordinate, attribute, final pixel of span
//   busy                             high while in SETUP or RUN
//
// Build option: ATTR_CLAMP_EN (see attr_fmt) selects saturating vs wrapping attribute.
module attr_span_eval
    import gpu_interp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               coef_load,
    input  logic [COEF_W-1:0]  cx,
    input  logic [COEF_W-1:0]  cy,
    input  logic [COEF_W-1:0]  cs,
    input  logic               span_valid,
    output logic               span_ready,
    input  logic [COORD_W-1:0] span_x,
    input  logic [COORD_W-1:0] span_y,
    input  logic [COORD_W-1:0] span_len,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [ATTR_W-1:0]  pix_s,
    output logic               pix_last,
    output logic               busy
);

    state_e state_q, state_d;

    logic [COEF_W-1:0]  cx_q, cx_d;
    logic [COEF_W-1:0]  cy_q, cy_d;
    logic [COEF_W-1:0]  cs_q, cs_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] rem_q, rem_d;

    logic               span_fire;
    logic               pix_fire;
    logic               last_pix;
    logic [ATTR_W-1:0]  fmt_s;

    assign span_fire = span_valid & span_ready;
    assign pix_fire  = pix_valid & pix_ready;
    assign last_pix  = (rem_q == COORD_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A zero-length span is consumed without leaving IDLE.
                if (span_fire && (span_len != '0)) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_RUN;
            ST_RUN: begin
                if (pix_fire && last_pix) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Pixel outputs are forced to zero outside RUN so nothing stale shows
    // after a span ends or is aborted by reset.
    always_comb begin
        span_ready = (state_q == ST_IDLE) & ~coef_load;
        busy       = (state_q == ST_SETUP) | (state_q == ST_RUN);
        pix_valid  = (state_q == ST_RUN);
        pix_x      = '0;
        pix_y      = '0;
        pix_s      = '0;
        pix_last   = 1'b0;
        if (state_q == ST_RUN) begin
            pix_x    = x_q;
            pix_y    = y_q;
            pix_s    = fmt_s;
            pix_last = last_pix;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        cx_d  = cx_q;
        cy_d  = cy_q;
        cs_d  = cs_q;
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        rem_d = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (coef_load) begin
                    cx_d = cx;
                    cy_d = cy;
                    cs_d = cs;
                end
                if (span_fire && (span_len != '0)) begin
                    x_d   = span_x;
                    y_d   = span_y;
                    rem_d = span_len;
                end
            end
            ST_SETUP: begin
                acc_d = sext_coef(cx_q) * zext_coord(x_q)
                      + sext_coef(cy_q) * zext_coord(y_q)
                      + sext_coef(cs_q);
            end
            ST_RUN: begin
                // The accumulator keeps stepping by cx even when x wraps past
                // 4095; x itself is a modulo-4096 screen coordinate.
                if (pix_fire) begin
                    acc_d = acc_q + sext_coef(cx_q);
                    x_d   = x_q + COORD_W'(1);
                    rem_d = rem_q - COORD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q  <= '0;
            cy_q  <= '0;
            cs_q  <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            rem_q <= '0;
        end else begin
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            cs_q  <= cs_d;
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            rem_q <= rem_d;
        end
    end

    attr_fmt u_attr_fmt (
        .acc_i  (acc_q),
        .attr_o (fmt_s)
    );

endmodule

// File: tb/tb_attr_span_eval.sv
// tb/tb_attr_span_eval.sv - self-checking bench for attr_span_eval (table vectors plus randomized spans)
module tb_attr_span_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        coef_load;
    logic [31:0] cx, cy, cs;
    logic        span_valid;
    logic        span_ready;
    logic [11:0] span_x, span_y, span_len;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_x, pix_y, pix_s;
    logic        pix_last;
    logic        busy;

    always #5 clk = ~clk;

    attr_span_eval dut (
        .clk        (clk),
        .rst        (rst),
        .coef_load  (coef_load),
        .cx         (cx),
        .cy         (cy),
        .cs         (cs),
        .span_valid (span_valid),
        .span_ready (span_ready),
        .span_x     (span_x),
        .span_y     (span_y),
        .span_len   (span_len),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_s      (pix_s),
        .pix_last   (pix_last),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // coefficients the DUT is expected to hold
    int m_cx = 0, m_cy = 0, m_cs = 0;

    typedef struct {
        bit load;
        int cx, cy, cs;
        int x, y, len;
        int mode;       // 0: always ready, 1: random ready + ignored coef_load, 2: stall pixel 1 for 3 cycles
        bit tbl;
        int exp_s0;
        int exp_xlast;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Attribute of pixel i of a span: evaluate the plane at (x0+i, y) exactly,
    // floor-divide by 256, then clamp or keep the low 12 bits.
    function automatic int model_s(int x0, int y, int i);
        longint a, sh;
        a  = longint'(m_cx) * longint'(x0 + i) + longint'(m_cy) * longint'(y) + longint'(m_cs);
        sh = a >>> 8;
`ifdef ATTR_CLAMP_EN
        if (sh < 0) return 0;
        if (sh > 4095) return 4095;
        return int'(sh);
`else
        return int'(sh & 64'hFFF);
`endif
    endfunction

    task automatic run_span(input vec_t v);
        int  i, cyc, stalls, ex, es;
        bit  el, pr;
        if (v.load) begin
            @(negedge clk);
            coef_load  = 1'b1;
            cx = v.cx; cy = v.cy; cs = v.cs;
            span_valid = 1'b1;
            span_x = 12'(v.x); span_y = 12'(v.y); span_len = 12'(v.len);
            #1 chk("ready_low_on_load", span_ready, 0);
            m_cx = v.cx; m_cy = v.cy; m_cs = v.cs;
        end
        @(negedge clk);
        coef_load  = 1'b0;
        cx = $urandom; cy = $urandom; cs = $urandom;
        span_valid = 1'b1;
        span_x = 12'(v.x); span_y = 12'(v.y); span_len = 12'(v.len);
        #1 chk("span_ready_idle", span_ready, 1);
        @(negedge clk);
        span_valid = 1'b0;
        span_len   = 12'($urandom);
        #1;
        if (v.len == 0) begin
            chk("len0_valid", pix_valid, 0);
            chk("len0_busy", busy, 0);
            chk("len0_ready", span_ready, 1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1 chk("len0_no_pixels", pix_valid | busy, 0);
            end
            return;
        end
        chk("setup_valid", pix_valid, 0);
        chk("setup_busy", busy, 1);
        pix_ready = 1'b1;
        @(negedge clk);
        #1 chk("first_pixel_latency", pix_valid, 1);
        i = 0; cyc = 0; stalls = 0;
        while (i < v.len && cyc < 200) begin
            cyc++;
            if (!pix_valid) begin
                chk("pix_valid_in_run", pix_valid, 1);
                break;
            end
            ex = (v.x + i) % 4096;
            es = model_s(v.x, v.y, i);
            el = (i == v.len - 1);
            checks++;
            if (pix_x != 12'(ex) || pix_y != 12'(v.y) || pix_s != 12'(es) || pix_last != el) begin
                errors++;
                $display("FAIL pixel[%0d] actual x=%0d y=%0d s=%0d last=%0d required x=%0d y=%0d s=%0d last=%0d",
                         i, pix_x, pix_y, pix_s, pix_last, ex, v.y, es, el);
            end
            if (v.tbl && i == 0)         chk("table_first_s", pix_s, v.exp_s0);
            if (v.tbl && i == v.len - 1) chk("table_last_x", pix_x, v.exp_xlast);
            case (v.mode)
                1:       pr = ($urandom_range(0, 3) != 0);
                2:       pr = !(i == 1 && stalls < 3);
                default: pr = 1'b1;
            endcase
            if (!pr) stalls++;
            pix_ready = pr;
            if (v.mode == 1) begin
                coef_load = 1'($urandom_range(0, 1));
                cx = $urandom;
            end
            if (pr) i++;
            @(negedge clk);
            #1;
        end
        if (cyc >= 200) chk("span_timeout", 1, 0);
        coef_load = 1'b0;
        pix_ready = 1'($urandom_range(0, 1));
        #1;
        chk("done_valid", pix_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", span_ready, 1);
        if (v.mode == 2) chk("stall_cycles", stalls, 3);
    endtask

    initial begin
        vec_t v;
        int   seen;

        rst = 1'b1; coef_load = 1'b0; cx = '0; cy = '0; cs = '0;
        span_valid = 1'b0; span_x = '0; span_y = '0; span_len = '0; pix_ready = 1'b0;

        //        load cx        cy      cs        x     y   len mode tbl s0  xlast
        tbl[0] = '{1, 'h100,     0,      'h500,    10,   3,  4,  0,   1,  15, 13};
        tbl[1] = '{1, 'h100,     0,      'h500,    10,   3,  4,  2,   1,  15, 13};
`ifdef ATTR_CLAMP_EN
        tbl[2] = '{1, -'h200,    0,      0,        5,    0,  1,  0,   1,  0,  5};
`else
        tbl[2] = '{1, -'h200,    0,      0,        5,    0,  1,  0,   1,  'hFF6, 5};
`endif
        tbl[3] = '{1, 'h100,     0,      'h500,    10,   3,  0,  0,   1,  0,  0};
        tbl[4] = '{1, 'h100,     0,      0,        4094, 0,  3,  0,   1,  4094, 0};
        tbl[5] = '{1, 'h80,      'h300,  -'h1000,  100,  50, 5,  1,   1,  184, 104};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", pix_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_xyz", {pix_x, pix_y, pix_s, pix_last}, 0);
        rst = 1'b0;
        #1 chk("ready_after_reset", span_ready, 1);

        for (int t = 0; t < 6; t++) run_span(tbl[t]);

        for (int t = 0; t < 20; t++) begin
            v.load = 1'b1;
            v.cx = $urandom; v.cy = $urandom; v.cs = $urandom;
            v.x = $urandom_range(0, 4095); v.y = $urandom_range(0, 4095);
            v.len = $urandom_range(0, 6);
            v.mode = 1; v.tbl = 1'b0; v.exp_s0 = 0; v.exp_xlast = 0;
            run_span(v);
        end

        // abort a len=8 span with reset after three pixels
        @(negedge clk);
        coef_load = 1'b1; cx = 32'h100; cy = 32'h0; cs = 32'h500;
        @(negedge clk);
        coef_load = 1'b0; span_valid = 1'b1; span_x = 12'd20; span_y = 12'd1; span_len = 12'd8;
        @(negedge clk);
        span_valid = 1'b0; pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1 chk("pre_abort_running", pix_valid & busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_valid", pix_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_outputs", {pix_x, pix_y, pix_s, pix_last}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_cx = 0; m_cy = 0; m_cs = 0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1 if (pix_valid || busy) seen++;
        end
        chk("no_residual_pixels", seen, 0);

        // coefficients were cleared by reset: a span without a load yields 0
        v = '{0, 0, 0, 0, 7, 9, 2, 0, 1, 0, 8};
        run_span(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/attr_span_eval.md
ATTR_SPAN_EVAL -- requirements
Module: attr_span_eval

Interface
REQ-001 SHALL have: clk  input  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-002 SHALL have: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have: coef_load  input  1  capture cx/cy/cs this cycle.
REQ-004 SHALL have: cx, cy, cs  input  32 each  signed plane coefficients, 8 fractional bits.
REQ-005 SHALL have: span_valid  input  1; span_ready  output  1  span request handshake.
REQ-006 SHALL have: span_x, span_y  input  12 each  unsigned start pixel; span_len  input  12  pixel count.
REQ-007 SHALL have: pix_valid  output  1; pix_ready  input  1  pixel output handshake.
REQ-008 SHALL have: pix_x, pix_y  output  12; pix_s  output  12  attribute; pix_last  output  1  final pixel of span.
REQ-009 SHALL have: busy  output  1  high in SETUP or RUN.

Function
REQ-010 SHALL implement states IDLE, SETUP, RUN.
REQ-011 coef_load SHALL update the coefficient registers only in IDLE; coef_load in SETUP/RUN is ignored.
REQ-012 span_ready SHALL equal (state==IDLE) & ~coef_load; same-cycle coef_load has priority over span acceptance.
REQ-013 Span accepted (span_valid & span_ready) with span_len!=0: latch x, y, len; IDLE->SETUP.
REQ-014 Span accepted with span_len==0: no pixels emitted, state stays IDLE.
REQ-015 SETUP (1 cycle): acc = cx*x + cy*y + cs, 48-bit signed, x/y zero-extended; SETUP->RUN.
REQ-016 RUN: pix_valid=1; pix_x=x, pix_y=y, pix_s=fmt(acc), pix_last=(remaining==1).
REQ-017 On pix_valid & pix_ready: acc += sign-extended cx; x = (x+1) mod 4096; remaining -= 1.
REQ-018 On acceptance of the pix_last pixel: RUN->IDLE; span_ready may rise the following cycle.
REQ-019 While pix_valid & ~pix_ready, all pix_* outputs SHALL hold stable.
REQ-020 fmt(acc) SHALL be acc arithmetically shifted right 8 (truncate toward -inf), then per REQ-025.
REQ-021 Latency: first pix_valid SHALL assert in the cycle after the clock edge ending SETUP (edge+2 after span acceptance); one pixel per cycle thereafter with pix_ready high.

Reset
REQ-022 rst SHALL force state IDLE, clear cx/cy/cs registers, acc, x, y, remaining.
REQ-023 During/after rst: pix_valid=0, pix_x=pix_y=pix_s=0, pix_last=0, busy=0, span_ready=1 once rst deasserts.
REQ-024 rst mid-span SHALL abort the span; no further pixels emitted for it.

Configuration
REQ-025 ATTR_CLAMP_EN defined: fmt SHALL saturate to 0 if negative, 4095 if >4095; undefined: pix_s SHALL be the low 12 bits of the shifted value (wrap).

Structure
REQ-026 Shared package gpu_interp_pkg SHALL hold COORD_W=12, ATTR_W=12, COEF_W=32, FRAC_BITS=8, ACC_W=48 and the state enum.
REQ-027 Sub-module attr_fmt SHALL implement fmt (shift plus clamp/wrap) combinationally.

Verification
REQ-028 cx=0x100, cy=0, cs=0x500, span x=10 y=3 len=4, pix_ready=1 -> pix_s 15,16,17,18; pix_x 10..13; pix_last on 4th only.
REQ-029 Same setup, pix_ready low 3 cycles on 2nd pixel -> pix_x=11, pix_s=16 held stable, then 17,18 follow.
REQ-030 cx=-0x200, cy=0, cs=0, x=5 len=1 -> pix_s=0 with ATTR_CLAMP_EN, 0xFF6 without.
REQ-031 span_len=0 accepted -> pix_valid never asserts, busy stays 0, span_ready high next cycle.
REQ-032 x=4094 len=3 -> pix_x 4094, 4095, 0.
REQ-033 rst asserted during RUN of a len=8 span -> pix_valid and busy 0 immediately; after release no residual pixels.
